// File: rtl/cpu_mem_responder.sv
// Unified RAM responder for the CPU fetch/data ports with a streaming boot loader.
// Optional write protection of the loaded image: CPU_MEM_RESPONDER_WRITE_PROTECT_EN.
module cpu_mem_responder #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int IO_FIFO_DEPTH = 4,
  parameter logic [WORD_WIDTH-1:0] IO_ADDR = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instr,
  input  logic [WORD_WIDTH-1:0] data_addr,
  input  logic [WORD_WIDTH-1:0] data_out,
  input  logic                  mem_write_en,
  output logic [WORD_WIDTH-1:0] data_in,
  output logic                  cpu_rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WORD_WIDTH-1:0] load_word,
  output logic                  io_valid,
  input  logic                  io_ready,
  output logic [WORD_WIDTH-1:0] io_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(IO_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_LEN,
    S_LOAD,
    S_RUN
  } state_t;

  state_t state, state_nx;
  logic [LW-1:0] len, len_nx;
  logic [LW-1:0] cnt, cnt_nx;
  logic ld_we;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic is_io, run_we, ram_we, wp_hit, wp_bit;

  logic [WORD_WIDTH-1:0] fifo [IO_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] f_cnt;
  logic full, push_req, push_ok, pop, overflow;

  logic unused_hi;
  assign unused_hi = ^pc[WORD_WIDTH-1:ADDR_WIDTH];

  assign i_idx = pc[ADDR_WIDTH-1:0];
  assign d_idx = data_addr[ADDR_WIDTH-1:0];
  assign is_io = data_addr == IO_ADDR;
  assign run_we = (state == S_RUN) && mem_write_en;

  always_comb begin
    state_nx = state;
    len_nx = len;
    cnt_nx = cnt;
    load_ready = 1'b0;
    ld_we = 1'b0;
    unique case (state)
      S_LEN: begin
        load_ready = 1'b1;
        if (load_valid) begin
          cnt_nx = '0;
          if (load_word == '0) begin
            len_nx = '0;
            state_nx = S_RUN;
          end else begin
            // lengths beyond the RAM are clamped to a full image
            if (32'(load_word) > 32'(DEPTH))
              len_nx = LW'(DEPTH);
            else
              len_nx = LW'(load_word);
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          ld_we = 1'b1;
          cnt_nx = cnt + LW'(1);
          if (cnt_nx == len) state_nx = S_RUN;
        end
      end
      S_RUN: ;
      default: state_nx = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LEN;
      len <= '0;
      cnt <= '0;
      cpu_rst <= 1'b0;
    end else begin
      state <= state_nx;
      len <= len_nx;
      cnt <= cnt_nx;
      cpu_rst <= state == S_RUN;
    end
  end

`ifdef CPU_MEM_RESPONDER_WRITE_PROTECT_EN
  logic wp_fault;
  assign wp_hit = {1'b0, d_idx} < len;
  assign wp_bit = wp_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wp_fault <= 1'b0;
    else if (run_we && !is_io && wp_hit)
      wp_fault <= 1'b1;
  end
`else
  assign wp_hit = 1'b0;
  assign wp_bit = 1'b0;
`endif

  assign ram_we = run_we && !is_io && !wp_hit;

  always_ff @(posedge clk) begin
    if (ld_we)
      mem[cnt[ADDR_WIDTH-1:0]] <= load_word;
    else if (ram_we)
      mem[d_idx] <= data_out;
  end

  assign instr = mem[i_idx];

  assign full = f_cnt == CW'(IO_FIFO_DEPTH);
  assign io_valid = f_cnt != '0;
  assign io_data = fifo[rd_ptr];
  assign pop = io_valid && io_ready;
  assign push_req = run_we && is_io;
  // a simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      f_cnt <= f_cnt + CW'(push_ok) - CW'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= data_out;
  end

  always_comb begin
    data_in = mem[d_idx];
    if (is_io)
      data_in = {{(WORD_WIDTH-3){1'b0}}, wp_bit, overflow, full};
  end

endmodule
